// File: rtl/ahb_master_bus_ctrl.sv
// AHB master-side bus controller: turns a local "transfer N beats" command into
// HBUSREQ/HLOCK arbitration followed by an INCR burst of word address phases.
// Handles RETRY/SPLIT (re-arbitrate and resume), ERROR (abort) and grant loss
// mid-burst (park, re-request, restart with NONSEQ at the next unissued beat).
module ahb_master_bus_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 5
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_write,
  input  logic              cmd_lock,
  output logic              HBUSREQ,
  output logic              HLOCK,
  input  logic              HGRANT,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  output logic [1:0]        HTRANS,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HBURST,
  output logic [2:0]        HSIZE,
  output logic              beat_done,
  output logic [LEN_W-1:0]  beat_idx,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  localparam logic [1:0] RespOkay  = 2'b00;
  localparam logic [1:0] RespError = 2'b01;

  // StErr holds for the second cycle of an ERROR response before reporting done.
  typedef enum logic [2:0] {StIdle, StReq, StAddr, StDrain, StErr} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   addr_cnt_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    iss_cnt_q;
  logic [LEN_W-1:0]    ret_cnt_q;
  logic                lock_q;

  logic                outstanding;
  logic                retire;
  logic                resp_abort;
  logic                last_accept;
  logic [LEN_W-1:0]    cmd_len_eff;
  logic [ADDR_W-1:0]   rewind_addr;

  assign HBURST = 3'b001;
  assign HSIZE  = 3'b010;

  // At most one beat is ever in its data phase: issued but not yet retired.
  assign outstanding = (iss_cnt_q != ret_cnt_q);
  assign retire      = outstanding && HREADY && (HRESP == RespOkay);
  // First cycle of a two-cycle RETRY/SPLIT/ERROR response to our own data phase.
  assign resp_abort  = outstanding && !HREADY && (HRESP != RespOkay);
  assign last_accept = ((iss_cnt_q + LEN_W'(1)) == len_q);
  assign cmd_len_eff = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
  assign rewind_addr = base_q + (ADDR_W'(ret_cnt_q) << 2);

  // Control FSM with registered bus and status outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= StIdle;
      base_q     <= '0;
      addr_cnt_q <= '0;
      len_q      <= '0;
      iss_cnt_q  <= '0;
      ret_cnt_q  <= '0;
      lock_q     <= 1'b0;
      cmd_ready  <= 1'b0;
      HBUSREQ    <= 1'b0;
      HLOCK      <= 1'b0;
      HTRANS     <= TransIdle;
      HADDR      <= '0;
      HWRITE     <= 1'b0;
      beat_done  <= 1'b0;
      beat_idx   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      beat_done <= 1'b0;
      done      <= 1'b0;

      if (retire) begin
        beat_done <= 1'b1;
        beat_idx  <= ret_cnt_q;
        ret_cnt_q <= ret_cnt_q + LEN_W'(1);
      end

      if (resp_abort) begin
        // Cancel the pipelined address and resume from the first unretired beat.
        HTRANS     <= TransIdle;
        addr_cnt_q <= rewind_addr;
        iss_cnt_q  <= ret_cnt_q;
        if (HRESP == RespError) begin
          HBUSREQ <= 1'b0;
          HLOCK   <= 1'b0;
          state_q <= StErr;
        end else begin
          HBUSREQ <= 1'b1;
          HLOCK   <= lock_q;
          state_q <= StReq;
        end
      end else begin
        case (state_q)
          StIdle: begin
            cmd_ready <= 1'b1;
            if (cmd_valid && cmd_ready) begin
              base_q     <= cmd_addr;
              addr_cnt_q <= cmd_addr;
              len_q      <= cmd_len_eff;
              iss_cnt_q  <= '0;
              ret_cnt_q  <= '0;
              lock_q     <= cmd_lock;
              HWRITE     <= cmd_write;
              HBUSREQ    <= 1'b1;
              HLOCK      <= cmd_lock;
              cmd_ready  <= 1'b0;
              state_q    <= StReq;
            end
          end
          StReq: begin
            if (HGRANT && HREADY) begin
              HTRANS  <= TransNonseq;
              HADDR   <= addr_cnt_q;
              state_q <= StAddr;
            end
          end
          StAddr: begin
            if (HREADY) begin
              addr_cnt_q <= addr_cnt_q + ADDR_W'(4);
              iss_cnt_q  <= iss_cnt_q + LEN_W'(1);
              if (last_accept) begin
                // HADDR is left on the final beat so it never runs past the burst.
                HTRANS  <= TransIdle;
                HBUSREQ <= 1'b0;
                HLOCK   <= 1'b0;
                state_q <= StDrain;
              end else if (!HGRANT) begin
                HTRANS  <= TransIdle;
                state_q <= StReq;
              end else begin
                HTRANS <= TransSeq;
                HADDR  <= addr_cnt_q + ADDR_W'(4);
              end
            end
          end
          StDrain: begin
            if (retire) begin
              done      <= 1'b1;
              err       <= 1'b0;
              cmd_ready <= 1'b1;
              state_q   <= StIdle;
            end
          end
          StErr: begin
            if (HREADY) begin
              done      <= 1'b1;
              err       <= 1'b1;
              cmd_ready <= 1'b1;
              state_q   <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
